// File: rtl/turf_trig_pkg.sv
// Shared types and constants for the TURF trigger processor.
//   trig_state_e : per-sector trigger FSM states.
//   NCH / NSCAL  : channel and scaler counts for the default geometry.
//                  nch_f / nscal_f give the same numbers for any geometry.
//   SCAL_SAT     : scaler saturation value for the default SCAL_W.
package turf_trig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } trig_state_e;

  localparam int NSECT_DEF  = 2;
  localparam int NRING_DEF  = 3;
  localparam int SCAL_W_DEF = 16;
  localparam int NCH        = NSECT_DEF * NRING_DEF;
  localparam int NSCAL      = NCH + NSECT_DEF;
  localparam logic [SCAL_W_DEF-1:0] SCAL_SAT = '1;

  function automatic int nch_f(input int nsect, input int nring);
    return nsect * nring;
  endfunction

  function automatic int nscal_f(input int nsect, input int nring);
    return nsect * nring + nsect;
  endfunction

endpackage

// File: rtl/turf_trig_stretch.sv
// Single-channel hit stretcher.
//   clk_i, rst_n_i : trigger clock, synchronous active-low reset
//   in_i           : registered hit
//   window_i       : extra cycles to hold the stretched output high
//   str_o          : registered stretched hit; a one-cycle hit gives
//                    window_i+1 cycles high, re-hits extend the window
module turf_trig_stretch
  import turf_trig_pkg::*;
#(
  parameter int WIN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_i,
  input  logic [WIN_W-1:0] window_i,
  output logic             str_o
);

  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic             str_q, str_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_i)
      cnt_d = window_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - WIN_W'(1);
    str_d = in_i | (cnt_q != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      str_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      str_q <= str_d;
    end
  end

  assign str_o = str_q;

endmodule

// File: rtl/turf_trigger_processor.sv
// TURF L1/L2 trigger processor.
//   clk_i, rst_n_i   : trigger clock, synchronous active-low reset
//   lcp_i, rcp_i     : tunnel-diode hits, channel index s*NRING+r
//   mask_i           : 1 forces L1 channel low
//   window_i         : coincidence stretch length (extra cycles)
//   l2_thresh_i      : rings needed per sector for an L2 (0 = off)
//   holdoff_i        : dead cycles after each trigger
//   ref_pulse_i      : scaler gate; rising edge latches scalers
//   trig_o           : one-cycle trigger per sector
//   l1_o             : registered L1 map
//   scal_o           : latched scalers, L1 channels then sector triggers
//   scal_valid_o     : one-cycle pulse after scal_o updates
// Build option TURF_PROC_SCALER_EN enables the scaler bank; without it
// scal_o/scal_valid_o are tied low and ref_pulse_i is ignored.
// Pipeline: in_q -> stretch -> l1_q -> FSM, 3 cycles sample-to-trigger.
module turf_trigger_processor
  import turf_trig_pkg::*;
#(
  parameter int NSECT  = 2,
  parameter int NRING  = 3,
  parameter int WIN_W  = 4,
  parameter int HOLD_W = 8,
  parameter int SCAL_W = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [NSECT*NRING-1:0]                    lcp_i,
  input  logic [NSECT*NRING-1:0]                    rcp_i,
  input  logic [NSECT*NRING-1:0]                    mask_i,
  input  logic [WIN_W-1:0]                          window_i,
  input  logic [$clog2(NRING+1)-1:0]                l2_thresh_i,
  input  logic [HOLD_W-1:0]                         holdoff_i,
  input  logic                                      ref_pulse_i,
  output logic [NSECT-1:0]                          trig_o,
  output logic [NSECT*NRING-1:0]                    l1_o,
  output logic [(NSECT*NRING+NSECT)*SCAL_W-1:0]     scal_o,
  output logic                                      scal_valid_o
);

  localparam int NC = nch_f(NSECT, NRING);
  localparam int NS = nscal_f(NSECT, NRING);
  localparam int TW = $clog2(NRING+1);

  // Stage 1: input register, LCP in the low half, RCP in the high half
  logic [2*NC-1:0] in_q, in_d;
  logic [2*NC-1:0] str;
  logic [NC-1:0]   l1_q, l1_d;

  always_comb in_d = {rcp_i, lcp_i};

  // Stage 2: one stretcher per polarisation per channel
  turf_trig_stretch #(.WIN_W(WIN_W)) u_str [2*NC-1:0] (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .in_i     (in_q),
    .window_i (window_i),
    .str_o    (str)
  );

  // Stage 3: masked coincidence
  always_comb l1_d = str[NC-1:0] & str[2*NC-1:NC] & ~mask_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_q <= '0;
      l1_q <= '0;
    end else begin
      in_q <= in_d;
      l1_q <= l1_d;
    end
  end

  assign l1_o = l1_q;

  // Stage 4: per-sector L2 majority and trigger/holdoff FSM
  for (genvar s = 0; s < NSECT; s++) begin : g_sect
    trig_state_e       st_q, st_d;
    logic [HOLD_W-1:0] hc_q, hc_d;
    logic [TW-1:0]     pop;

    always_comb begin
      pop = '0;
      for (int r = 0; r < NRING; r++)
        pop = pop + TW'(l1_q[s*NRING+r]);
    end

    always_comb begin
      st_d = st_q;
      hc_d = hc_q;
      case (st_q)
        IDLE: if (l2_thresh_i != '0 && pop >= l2_thresh_i) st_d = FIRE;
        FIRE: begin
          hc_d = holdoff_i;
          st_d = (holdoff_i == '0) ? IDLE : HOLD;
        end
        HOLD: begin
          // leaves on the cycle the count reaches 0: holdoff_i dead cycles
          hc_d = hc_q - HOLD_W'(1);
          if (hc_q == HOLD_W'(1)) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        st_q <= IDLE;
        hc_q <= '0;
      end else begin
        st_q <= st_d;
        hc_q <= hc_d;
      end
    end

    assign trig_o[s] = (st_q == FIRE);
  end

`ifdef TURF_PROC_SCALER_EN
  localparam logic [SCAL_W-1:0] SAT = {SCAL_W{1'b1}};

  logic [NC-1:0]             l1_prev_q;
  logic                      ref_q, ref_hist_q, vpend_q, sv_q;
  logic                      latch_c;
  logic [NS-1:0]             ev;
  logic [NS-1:0][SCAL_W-1:0] cnt_q, cnt_d, scal_q, scal_d;

  always_comb begin
    ev      = {trig_o, l1_q & ~l1_prev_q};
    latch_c = ref_q & ~ref_hist_q;
    cnt_d   = cnt_q;
    scal_d  = scal_q;
    for (int i = 0; i < NS; i++) begin
      if (latch_c) begin
        // latch the closed period; an event this cycle opens the next one
        scal_d[i] = cnt_q[i];
        cnt_d[i]  = SCAL_W'(ev[i]);
      end else if (ev[i] && cnt_q[i] != SAT) begin
        cnt_d[i]  = cnt_q[i] + SCAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      l1_prev_q  <= '0;
      ref_q      <= 1'b0;
      ref_hist_q <= 1'b0;
      vpend_q    <= 1'b0;
      sv_q       <= 1'b0;
      cnt_q      <= '0;
      scal_q     <= '0;
    end else begin
      l1_prev_q  <= l1_q;
      ref_q      <= ref_pulse_i;
      ref_hist_q <= ref_q;
      vpend_q    <= latch_c;
      sv_q       <= vpend_q;
      cnt_q      <= cnt_d;
      scal_q     <= scal_d;
    end
  end

  assign scal_o       = scal_q;
  assign scal_valid_o = sv_q;
`else
  logic unused_ref;
  assign unused_ref   = ref_pulse_i;
  assign scal_o       = '0;
  assign scal_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_turf_trigger_processor.sv
module tb_turf_trigger_processor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   lcp, rcp, mask;
  logic [3:0]   window;
  logic [1:0]   thresh;
  logic [7:0]   holdoff;
  logic         ref_p;
  logic [1:0]   trig, trig4;
  logic [5:0]   l1, l14;
  logic [127:0] scal;
  logic [31:0]  scal4;
  logic         sv, sv4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  turf_trigger_processor dut (
    .clk_i(clk), .rst_n_i(rst_n), .lcp_i(lcp), .rcp_i(rcp), .mask_i(mask),
    .window_i(window), .l2_thresh_i(thresh), .holdoff_i(holdoff),
    .ref_pulse_i(ref_p), .trig_o(trig), .l1_o(l1), .scal_o(scal),
    .scal_valid_o(sv)
  );

  turf_trigger_processor #(.SCAL_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .lcp_i(lcp), .rcp_i(rcp), .mask_i(mask),
    .window_i(window), .l2_thresh_i(thresh), .holdoff_i(holdoff),
    .ref_pulse_i(ref_p), .trig_o(trig4), .l1_o(l14), .scal_o(scal4),
    .scal_valid_o(sv4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive a one-cycle LCP+RCP hit on the given channels, then one idle cycle
  task automatic pulse(input logic [5:0] m);
    lcp = m; rcp = m;
    step(1);
    lcp = '0; rcp = '0;
    step(1);
  endtask

  initial begin
    int cnt1;
    int np;
    int tt[4];
    logic acc;

    rst_n = 1'b0; lcp = '0; rcp = '0; mask = '0; window = 4'd2;
    thresh = 2'd2; holdoff = 8'd0; ref_p = 1'b0;
    step(3);
    chk("rst_trig", {trig4, trig}, 4'b0);
    chk("rst_l1", {l14, l1}, 12'b0);
    chk("rst_scal", {scal4, scal}, 160'b0);
    chk("rst_sv", {sv4, sv}, 2'b0);
    rst_n = 1'b1;
    step(2);

    // basic L2: rings 0,1 of sector 0, hit sampled at edge e1
    pulse(6'b000011);                                   // now after e2
    chk("t1_l1_e2", l1, 6'b0);
    step(1); chk("t1_l1_e3", l1, 6'b000011); chk("t1_trig_e3", trig, 2'b00);
    step(1); chk("t1_trig_e4", trig, 2'b01); chk("t1_trig4_e4", trig4, 2'b01);
    step(1); chk("t1_trig_e5", trig, 2'b00); chk("t1_l1_e5", l1, 6'b000011);
    step(1); chk("t1_l1_e6", l1, 6'b0);
    step(6);

    // coincidence window: LCP at cycle 0, RCP at cycle 3
    cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      lcp = (c == 0) ? 6'b1 : 6'b0;
      rcp = (c == 3) ? 6'b1 : 6'b0;
      step(1);
      cnt1 += int'(l1[0]);
    end
    chk("t2_win2", cnt1, 0);
    window = 4'd3;
    step(4);
    cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      lcp = (c == 0) ? 6'b1 : 6'b0;
      rcp = (c == 3) ? 6'b1 : 6'b0;
      step(1);
      cnt1 += int'(l1[0]);
    end
    chk("t2_win3", cnt1, 1);
    step(4);

    // continuous condition with holdoff 5: spacing 7
    window = 4'd0; holdoff = 8'd5;
    lcp = 6'b000011; rcp = 6'b000011;
    np = 0; acc = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      acc |= trig[1];
      if (trig[0] && np < 4) begin
        tt[np] = c;
        np++;
      end
    end
    chk("t3_npulses", np >= 3, 1'b1);
    chk("t3_space01", tt[1] - tt[0], 7);
    chk("t3_space12", tt[2] - tt[1], 7);
    chk("t3_sect1", acc, 1'b0);

    // threshold 0 disables triggering
    thresh = 2'd0;
    step(8);
    acc = 1'b0;
    for (int c = 0; c < 20; c++) begin step(1); acc |= trig[0]; end
    chk("t4_thresh0", acc, 1'b0);

    // masked ring 1 leaves only one ring: no L2 at threshold 2
    mask = 6'b000010;
    step(3);
    chk("t5_l1_masked", l1, 6'b000001);
    thresh = 2'd2;
    acc = 1'b0;
    for (int c = 0; c < 20; c++) begin step(1); acc |= trig[0]; end
    chk("t5_mask", acc, 1'b0);

    lcp = '0; rcp = '0; mask = '0; holdoff = 8'd0;
    step(8);

`ifdef TURF_PROC_SCALER_EN
    // close whatever period the earlier tests built up
    ref_p = 1'b1; step(4); ref_p = 1'b0; step(2);

    // 10 edges, then an 11th whose l1 rise lands on the latch cycle
    for (int i = 0; i < 10; i++) pulse(6'b000001);
    pulse(6'b000001);
    ref_p = 1'b1;
    step(1);                                            // ref sampled high
    step(1); chk("s1_sv_k1", sv, 1'b0);
    step(1);
    chk("s1_sv_k2", sv, 1'b1);
    chk("s1_ch0", scal[15:0], 16'd10);
    chk("s1_trig0", scal[111:96], 16'd0);
    chk("s1_ch0_w4", scal4[3:0], 4'd10);
    step(1); chk("s1_sv_k3", sv, 1'b0);
    ref_p = 1'b0;
    step(3);
    ref_p = 1'b1;
    step(3);
    chk("s2_coinc", scal[15:0], 16'd1);
    ref_p = 1'b0;

    // saturation of the 4-bit scaler
    for (int i = 0; i < 20; i++) pulse(6'b000001);
    step(4);
    ref_p = 1'b1;
    step(3);
    chk("s3_ch0_20", scal[15:0], 16'd20);
    chk("s3_sat_w4", scal4[3:0], 4'd15);
    ref_p = 1'b0;
    step(3);
`else
    ref_p = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 6; c++) begin step(1); acc |= sv | sv4; end
    ref_p = 1'b0;
    chk("nos_sv", acc, 1'b0);
    chk("nos_scal", {scal4, scal}, 160'b0);
`endif

    // reset in the middle of a long holdoff
    holdoff = 8'd20;
    pulse(6'b000011);
    step(1);
    step(1); chk("r_trig_pre", trig, 2'b01);
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("r_trig", trig, 2'b00);
    chk("r_l1", l1, 6'b0);
    chk("r_scal", scal, 128'b0);
    chk("r_sv", sv, 1'b0);
    rst_n = 1'b1;
    step(1);
    pulse(6'b000011);
    step(1);
    step(1); chk("r_refire", trig, 2'b01);
`ifdef TURF_PROC_SCALER_EN
    step(3);
    ref_p = 1'b1;
    step(3);
    chk("r_sv_post", sv, 1'b1);
    chk("r_ch0_post", scal[15:0], 16'd1);
    chk("r_trig0_post", scal[111:96], 16'd1);
    chk("r_trig1_post", scal[127:112], 16'd0);
    ref_p = 1'b0;
`endif
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
